alu_serial: RTL and testbench

//  Multi-cycle, slice-serial successor to the 4-bit ALU slice. Operates on

---
 rtl/alu_serial_if.sv | 33 +++
 rtl/alu_serial.sv | 143 ++++++++++++++
 tb/tb_alu_serial.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_serial_if                                                   |
// | Brief    : Sequencer <-> serial ALU bundle (start/busy/done, operands).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface alu_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             m;
   logic [3:0]       s;
   logic             crin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] f;
   logic             crout;
   logic             zero;
   logic             illegal;

   modport master (
      output start, m, s, crin, a, b,
      input  busy, done, f, crout, zero, illegal
   );

   modport slave (
      input  start, m, s, crin, a, b,
      output busy, done, f, crout, zero, illegal
   );
endinterface
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_serial                                                      |
// | Brief    : Slice-serial ALU, SLICE bits per clock, LSB slice first.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   alu_serial_if.slave alu_if
);
   localparam int N     = WIDTH / SLICE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_param_err
      $error("alu_serial: WIDTH must be a non-zero multiple of SLICE");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, acc_q;
   logic               m_q, carry_q;
   logic [3:0]         s_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q, done_q, crout_q, zero_q, illegal_q;
   logic [WIDTH-1:0]   f_q;

   logic [SLICE-1:0]   slice_a, slice_b, slice_res;
   logic [SLICE:0]     slice_sum;
   logic               slice_cout, op_legal;
   logic [WIDTH-1:0]   acc_d, f_d;

   always_comb begin
      op_legal = (!m_q && (s_q == 4'h0 || s_q == 4'h6 || s_q == 4'h9)) ||
                 ( m_q && (s_q == 4'h1 || s_q == 4'hA));
   end

   always_comb begin
      slice_a    = a_q[SLICE-1:0];
      slice_b    = b_q[SLICE-1:0];
      slice_sum  = '0;
      slice_res  = '0;
      slice_cout = 1'b0;
      if (!m_q) begin
         case (s_q)
            4'h0:    slice_sum = {1'b0, slice_a} + {{SLICE{1'b0}}, carry_q};
            4'h6:    slice_sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {{SLICE{1'b0}}, carry_q};
            4'h9:    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
            default: slice_sum = '0;
         endcase
         slice_res  = slice_sum[SLICE-1:0];
         slice_cout = slice_sum[SLICE];
      end else begin
         case (s_q)
            4'h1:    slice_res = ~(slice_a | slice_b);
            4'hA:    slice_res = slice_b;
            default: slice_res = '0;
         endcase
      end
   end

   // New slice enters at the top so the LSB slice ends up at bit 0 after N shifts.
   always_comb begin
      acc_d = (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
      f_d   = op_legal ? acc_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         m_q       <= 1'b0;
         s_q       <= 4'h0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         f_q       <= '0;
         crout_q   <= 1'b0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               done_q <= 1'b0;
               if (alu_if.start) begin
                  a_q     <= alu_if.a;
                  b_q     <= alu_if.b;
                  m_q     <= alu_if.m;
                  s_q     <= alu_if.s;
                  carry_q <= alu_if.crin;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> SLICE;
               b_q     <= b_q >> SLICE;
               acc_q   <= acc_d;
               carry_q <= slice_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N - 1)) begin
                  f_q       <= f_d;
                  crout_q   <= op_legal && !m_q && slice_cout;
                  zero_q    <= (f_d == '0);
                  illegal_q <= !op_legal;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  state_q   <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_if.busy    = busy_q;
   assign alu_if.done    = done_q;
   assign alu_if.f       = f_q;
   assign alu_if.crout   = crout_q;
   assign alu_if.zero    = zero_q;
   assign alu_if.illegal = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_serial                                                   |
// | Brief    : Directed self-checking bench, 8/4 and 16/4 configurations.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_serial;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   alu_serial_if #(.WIDTH(8))  if8  ();
   alu_serial_if #(.WIDTH(16)) if16 ();

   alu_serial #(.WIDTH(8),  .SLICE(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .alu_if(if8.slave));
   alu_serial #(.WIDTH(16), .SLICE(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .alu_if(if16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                         input logic [3:0] ts, input logic tc);
      if8.a = ta; if8.b = tb; if8.m = tm; if8.s = ts; if8.crin = tc;
   endtask

   // Full single op on the 8-bit DUT; inputs applied on a falling edge.
   task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tm, input logic [3:0] ts, input logic tc,
                      input logic [7:0] ef, input logic ec, input logic ez, input logic eil);
      int lat;
      int nb;
      @(negedge clk);
      drive8(ta, tb, tm, ts, tc);
      if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      lat = 1;
      nb  = 0;
      while (!if8.done && lat < 20) begin
         if (if8.busy) nb++;
         @(negedge clk);
         lat++;
      end
      check_val({tag, ".lat"},   lat, 3);
      check_val({tag, ".busy"},  nb, 2);
      check_val({tag, ".f"},     if8.f, ef);
      check_val({tag, ".crout"}, if8.crout, ec);
      check_val({tag, ".zero"},  if8.zero, ez);
      check_val({tag, ".ill"},   if8.illegal, eil);
      @(negedge clk);
      check_val({tag, ".pulse"}, if8.done, 0);
      check_val({tag, ".hold"},  if8.f, ef);
   endtask

   initial begin
      int lat;
      int nb;
      int dcount;
      rst_n = 1'b0;
      if8.start = 1'b0;  drive8(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);
      if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.m = 1'b0; if16.s = 4'h0; if16.crin = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst.busy", if8.busy, 0);
      check_val("rst.done", if8.done, 0);
      check_val("rst.f",    if8.f, 0);
      check_val("rst.flags", {if8.crout, if8.zero, if8.illegal}, 0);
      rst_n = 1'b1;

      op8("add1",  8'h9F, 8'h01, 1'b0, 4'h9, 1'b0, 8'hA0, 1'b0, 1'b0, 1'b0);
      op8("add2",  8'hFF, 8'h01, 1'b0, 4'h9, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      op8("sub1",  8'h10, 8'h01, 1'b0, 4'h6, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
      op8("sub2",  8'h01, 8'h02, 1'b0, 4'h6, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      op8("inc",   8'h0F, 8'h77, 1'b0, 4'h0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
      op8("nor",   8'hF0, 8'h0C, 1'b1, 4'h1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      op8("passb", 8'h33, 8'h5A, 1'b1, 4'hA, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      op8("ill",   8'hFF, 8'h01, 1'b0, 4'h3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

      // Back-to-back: start held through DONE.
      @(negedge clk);
      drive8(8'h9F, 8'h01, 1'b0, 4'h9, 1'b0);
      if8.start = 1'b1;
      repeat (3) @(negedge clk);
      check_val("b2b.done1", if8.done, 1);
      check_val("b2b.f1",    if8.f, 8'hA0);
      drive8(8'hFF, 8'h01, 1'b0, 4'h9, 1'b0);
      @(negedge clk);
      check_val("b2b.busy2", if8.busy, 1);
      check_val("b2b.done2lo", if8.done, 0);
      if8.start = 1'b0;
      repeat (2) @(negedge clk);
      check_val("b2b.done2", if8.done, 1);
      check_val("b2b.f2",    {if8.crout, if8.f}, 9'h100);

      // Start pulsed during RUN with disturbed operands.
      @(negedge clk);
      drive8(8'h9F, 8'h01, 1'b0, 4'h9, 1'b0);
      if8.start = 1'b1;
      @(negedge clk);
      drive8(8'h00, 8'h00, 1'b1, 4'h3, 1'b1);
      @(negedge clk);
      if8.start = 1'b0;
      @(negedge clk);
      check_val("ign.done", if8.done, 1);
      check_val("ign.f",    if8.f, 8'hA0);
      @(negedge clk);
      check_val("ign.idle", if8.busy, 0);

      // Reset in the first RUN cycle.
      @(negedge clk);
      drive8(8'hFF, 8'h01, 1'b0, 4'h9, 1'b0);
      if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      check_val("rr.busy_pre", if8.busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("rr.busy", if8.busy, 0);
      check_val("rr.f",    if8.f, 0);
      check_val("rr.flags", {if8.done, if8.crout, if8.zero, if8.illegal}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (if8.done || if8.busy) dcount++;
      end
      check_val("rr.nodone", dcount, 0);

      // 16-bit configuration, N = 4.
      @(negedge clk);
      if16.a = 16'hFFFF; if16.b = 16'h0001; if16.m = 1'b0; if16.s = 4'h9; if16.crin = 1'b0;
      if16.start = 1'b1;
      @(negedge clk);
      if16.start = 1'b0;
      lat = 1;
      nb  = 0;
      while (!if16.done && lat < 20) begin
         if (if16.busy) nb++;
         @(negedge clk);
         lat++;
      end
      check_val("w16.lat",   lat, 5);
      check_val("w16.busy",  nb, 4);
      check_val("w16.f",     if16.f, 16'h0000);
      check_val("w16.crout", if16.crout, 1);
      check_val("w16.zero",  if16.zero, 1);
      check_val("w16.dut8",  if8.done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
